// File: rtl/traffic_light_top.sv
// Traffic light controller: RED -> YEL1 -> GREEN -> GBLINK -> YEL2 -> RED,
// with a synchronized "force red" button that parks the light in FORCE while held.
module traffic_light_top #(
  parameter int unsigned T_RED    = 200,
  parameter int unsigned T_YEL1   = 50,
  parameter int unsigned T_GREEN  = 200,
  parameter int unsigned T_GBLINK = 60,
  parameter int unsigned T_YEL2   = 50,
  parameter int unsigned T_TOGGLE = 10
) (
  input  logic clk,
  input  logic btn_res,
  input  logic btn,
  output logic led0,
  output logic led1,
  output logic led2
);

  localparam int unsigned CNT_W = 16;
  localparam int unsigned ST_W  = 3;
  localparam int unsigned LED_W = 3;

  localparam logic [2:0] ST_RED    = 3'd0;
  localparam logic [2:0] ST_YEL1   = 3'd1;
  localparam logic [2:0] ST_GREEN  = 3'd2;
  localparam logic [2:0] ST_GBLINK = 3'd3;
  localparam logic [2:0] ST_YEL2   = 3'd4;
  localparam logic [2:0] ST_FORCE  = 3'd5;

  // Last counter value of each timed phase
  localparam logic [CNT_W-1:0] RED_LAST    = CNT_W'(T_RED - 1);
  localparam logic [CNT_W-1:0] YEL1_LAST   = CNT_W'(T_YEL1 - 1);
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] GBLINK_LAST = CNT_W'(T_GBLINK - 1);
  localparam logic [CNT_W-1:0] YEL2_LAST   = CNT_W'(T_YEL2 - 1);
  localparam logic [CNT_W-1:0] TOG_LAST    = CNT_W'(T_TOGGLE - 1);

  // Lamp vector ordering: {green, yellow, red}
  localparam logic [LED_W-1:0] LED_RED    = 3'b001;
  localparam logic [LED_W-1:0] LED_YELLOW = 3'b010;
  localparam logic [LED_W-1:0] LED_GREEN  = 3'b100;
  localparam logic [LED_W-1:0] LED_OFF    = 3'b000;

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             btn_s;
  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tog_q, tog_d;
  logic             blink_q, blink_d;
  logic [LED_W-1:0] led_q, led_d;
  logic [CNT_W-1:0] phase_last;
  logic [ST_W-1:0]  phase_next;

  assign btn_s = sync2_q;

  // Per-state timing and successor in the normal cycle
  always_comb begin
    phase_last = '0;
    phase_next = ST_RED;
    case (state_q)
      ST_RED: begin
        phase_last = RED_LAST;
        phase_next = ST_YEL1;
      end
      ST_YEL1: begin
        phase_last = YEL1_LAST;
        phase_next = ST_GREEN;
      end
      ST_GREEN: begin
        phase_last = GREEN_LAST;
        phase_next = ST_GBLINK;
      end
      ST_GBLINK: begin
        phase_last = GBLINK_LAST;
        phase_next = ST_YEL2;
      end
      ST_YEL2: begin
        phase_last = YEL2_LAST;
        phase_next = ST_RED;
      end
      ST_FORCE: begin
        phase_last = '0;
        phase_next = ST_FORCE;
      end
      default: begin
        phase_last = '0;
        phase_next = ST_RED;
      end
    endcase
  end

  // Next state, phase counter, blink phase and lamp decode
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    tog_d   = '0;
    blink_d = 1'b1;
    led_d   = LED_RED;

    if (state_q == ST_FORCE) begin
      cnt_d = '0;
      if (!btn_s) begin
        state_d = ST_RED;
      end
    end else if (btn_s) begin
      state_d = ST_FORCE;
      cnt_d   = '0;
    end else if (cnt_q == phase_last) begin
      state_d = phase_next;
      cnt_d   = '0;
    end else if (state_q > ST_FORCE) begin
      state_d = ST_RED;
      cnt_d   = '0;
    end

    // Blink phase restarts lit on every entry into GBLINK
    if ((state_q == ST_GBLINK) && (state_d == ST_GBLINK)) begin
      if (tog_q == TOG_LAST) begin
        tog_d   = '0;
        blink_d = ~blink_q;
      end else begin
        tog_d   = tog_q + CNT_W'(1);
        blink_d = blink_q;
      end
    end

    case (state_d)
      ST_RED:    led_d = LED_RED;
      ST_YEL1:   led_d = LED_YELLOW;
      ST_GREEN:  led_d = LED_GREEN;
      ST_GBLINK: led_d = blink_d ? LED_GREEN : LED_OFF;
      ST_YEL2:   led_d = LED_YELLOW;
      ST_FORCE:  led_d = LED_RED;
      default:   led_d = LED_RED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!btn_res) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_RED;
      cnt_q   <= '0;
      tog_q   <= '0;
      blink_q <= 1'b1;
      led_q   <= LED_RED;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tog_q   <= tog_d;
      blink_q <= blink_d;
      led_q   <= led_d;
    end
  end

  assign led0 = led_q[0];
  assign led1 = led_q[1];
  assign led2 = led_q[2];

endmodule

// File: tb/tb_traffic_light_top.sv
// Bench for traffic_light_top: phase-table model checked every cycle, plus
// hand-computed lamp expectations at key points of the sequence.
module tb_traffic_light_top;

  localparam int T_RED    = 200;
  localparam int T_YEL1   = 50;
  localparam int T_GREEN  = 200;
  localparam int T_GBLINK = 60;
  localparam int T_YEL2   = 50;
  localparam int T_TOGGLE = 10;

  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;
  localparam logic [2:0] OFF = 3'b000;

  logic clk = 1'b0;
  logic btn_res;
  logic btn;
  logic led0, led1, led2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  traffic_light_top #(
    .T_RED(T_RED), .T_YEL1(T_YEL1), .T_GREEN(T_GREEN),
    .T_GBLINK(T_GBLINK), .T_YEL2(T_YEL2), .T_TOGGLE(T_TOGGLE)
  ) dut (
    .clk(clk), .btn_res(btn_res), .btn(btn),
    .led0(led0), .led1(led1), .led2(led2)
  );

  always #5 clk = ~clk;

  // Model: phase index into a duration table, elapsed cycles, force flag
  int   dur [5];
  int   m_phase = 0;
  int   m_el    = 0;
  bit   m_force = 1'b0;
  bit   m_valid = 1'b0;
  bit   m_s1 = 1'b0, m_s2 = 1'b0;

  initial begin
    dur[0] = T_RED; dur[1] = T_YEL1; dur[2] = T_GREEN;
    dur[3] = T_GBLINK; dur[4] = T_YEL2;
  end

  always @(posedge clk) begin
    bit bs;
    if (btn_res === 1'b0) begin
      m_phase = 0; m_el = 0; m_force = 1'b0;
      m_s1 = 1'b0; m_s2 = 1'b0; m_valid = 1'b1;
    end else begin
      bs = m_s2; m_s2 = m_s1; m_s1 = btn;
      if (m_force) begin
        if (!bs) begin m_force = 1'b0; m_phase = 0; m_el = 0; end
      end else if (bs) begin
        m_force = 1'b1; m_el = 0;
      end else begin
        m_el++;
        if (m_el == dur[m_phase]) begin
          m_phase = (m_phase + 1) % 5;
          m_el = 0;
        end
      end
    end
  end

  function automatic logic [2:0] model_leds();
    if (m_force) return RED;
    case (m_phase)
      0:       return RED;
      1, 4:    return YEL;
      2:       return GRN;
      default: return ((m_el % (2 * T_TOGGLE)) < T_TOGGLE) ? GRN : OFF;
    endcase
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic [2:0] got;
    cyc++;
    if (m_valid) begin
      got = {led2, led1, led0};
      n_checks++;
      if (got !== model_leds()) begin
        n_fail++;
        $display("FAIL model_cmp t=%0t: leds got %b want %b", $time, got, model_leds());
      end
      n_checks++;
      if ($countones(got) > 1) begin
        n_fail++;
        $display("FAIL one_lamp t=%0t: leds got %b want at most one lit", $time, got);
      end
    end
  end

  task automatic check_leds(input string name, input logic [2:0] exp);
    logic [2:0] got;
    got = {led2, led1, led0};
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t: leds got %b want %b", name, $time, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk) btn_res = 1'b0;
    @(negedge clk) btn_res = 1'b1;
  endtask

  initial begin
    btn = 1'b0;
    btn_res = 1'b1;
    step(3);

    // Normal cycle after reset (n = cycles since reset edge)
    do_reset();
    check_leds("reset_red", RED);
    step(199); check_leds("red_n199", RED);
    step(1);   check_leds("yel1_n200", YEL);
    step(49);  check_leds("yel1_n249", YEL);
    step(1);   check_leds("green_n250", GRN);
    step(199); check_leds("green_n449", GRN);
    step(1);   check_leds("blink_on_n450", GRN);
    step(9);   check_leds("blink_on_n459", GRN);
    step(1);   check_leds("blink_off_n460", OFF);
    step(10);  check_leds("blink_on_n470", GRN);
    step(39);  check_leds("blink_off_n509", OFF);
    step(1);   check_leds("yel2_n510", YEL);
    step(50);  check_leds("red_n560", RED);

    // Force mid-green, held 1505 cycles
    step(350); check_leds("green_n910", GRN);
    btn = 1'b1;
    step(2);    check_leds("force_sync_2", GRN);
    step(1);    check_leds("force_3", RED);
    step(1502); check_leds("force_held", RED);
    btn = 1'b0;
    step(202);  check_leds("post_force_red", RED);
    step(1);    check_leds("post_force_yel", YEL);

    // Reset during YEL2
    step(320); check_leds("yel2_before_rst", YEL);
    do_reset();
    check_leds("rst_yel2_red", RED);
    step(199); check_leds("rst_yel2_n199", RED);
    step(1);   check_leds("rst_yel2_n200", YEL);

    // Reset during FORCE, button released together with reset
    btn = 1'b1;
    step(10); check_leds("force_again", RED);
    btn_res = 1'b0; btn = 1'b0;
    step(1); btn_res = 1'b1;
    check_leds("rst_force_red", RED);
    step(199); check_leds("rst_force_n199", RED);
    step(1);   check_leds("rst_force_n200", YEL);

    // Button held through reset: FORCE entered after release, delays yellow
    btn = 1'b1; btn_res = 1'b0;
    step(3); check_leds("rst_btn_held", RED);
    btn_res = 1'b1;
    step(10); btn = 1'b0;
    step(202); check_leds("rst_btn_n212", RED);
    step(1);   check_leds("rst_btn_n213", YEL);

    // Random button activity with occasional resets
    begin
      int start = cyc;
      while (cyc - start < 15000) begin
        if ($urandom_range(0, 9) == 0) do_reset();
        btn = 1'b1;
        step($urandom_range(1, 40));
        btn = 1'b0;
        step($urandom_range(1, 700));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
